// File: rtl/seg7_scan_driver.sv
// Scan controller for a 4-digit common-anode 7-segment display feeding a BCD decoder.
// Frame-synchronous value buffering, per-slot dead time, leading-zero blanking, lamp test.
module seg7_scan_driver #(
    parameter int CLK_DIV      = 1000,
    parameter int BLANK_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] value,
    input  logic        load,
    input  logic        display_on,
    input  logic        lamp_test,
    input  logic        blank_lz,
    output logic        bcd_d,
    output logic        bcd_c,
    output logic        bcd_b,
    output logic        bcd_a,
    output logic        dec_enable,
    output logic        dec_all_on,
    output logic [3:0]  dig_sel,
    output logic        frame_start,
    output logic        bcd_err
);

    localparam int            CW       = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] BLANK_N  = CW'(BLANK_CYCLES);

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } state_t;

    localparam state_t ST_RST = (BLANK_CYCLES == 0) ? DRIVE : BLANK;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [1:0]    slot, slot_nxt;
    logic          wrap, frame_end;

    logic [15:0]   pend, disp;
    logic          pend_v;

    assign wrap      = (cnt == CNT_LAST);
    assign frame_end = wrap && (slot == 2'd3);

    // Slot sequencing: state always tracks whether cnt is inside the dead-time window
    always_comb begin
        cnt_nxt   = wrap ? '0 : cnt + 1'b1;
        slot_nxt  = wrap ? slot + 2'd1 : slot;
        state_nxt = state;
        case (state)
            BLANK: if (cnt_nxt == BLANK_N) state_nxt = DRIVE;
            DRIVE: if (wrap) state_nxt = ST_RST;
            default: state_nxt = ST_RST;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_RST;
            cnt   <= '0;
            slot  <= 2'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            slot  <= slot_nxt;
        end
    end

    // A load landing on the frame boundary bypasses pend so it shows in the new frame
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend   <= '0;
            pend_v <= 1'b0;
            disp   <= '0;
        end else if (frame_end) begin
            if (load)
                disp <= value;
            else if (pend_v)
                disp <= pend;
            if (load)
                pend <= value;
            pend_v <= 1'b0;
        end else if (load) begin
            pend   <= value;
            pend_v <= 1'b1;
        end
    end

    logic [3:0] cur_dig;
    logic [3:0] hi_zero;
    logic       lz_blank;
    logic       drive;

    always_comb begin
        cur_dig    = disp[{slot, 2'b00} +: 4];
        hi_zero[0] = 1'b0;
        hi_zero[1] = (disp[15:4]  == 12'd0);
        hi_zero[2] = (disp[15:8]  == 8'd0);
        hi_zero[3] = (disp[15:12] == 4'd0);
        lz_blank   = blank_lz && !lamp_test && hi_zero[slot];
        drive      = display_on && (state == DRIVE);
    end

    logic [3:0] sel_d, nib_d;
    logic       en_d, all_on_d, fs_d, err_d;

    always_comb begin
        sel_d    = drive ? ~(4'b0001 << slot) : 4'b1111;
        nib_d    = cur_dig;
        en_d     = drive && !lz_blank;
        all_on_d = drive && lamp_test;
        fs_d     = display_on && (slot == 2'd0) && (cnt == '0);
        err_d    = drive && (cnt == BLANK_N) && (cur_dig > 4'd9);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dig_sel                      <= 4'b1111;
            {bcd_d, bcd_c, bcd_b, bcd_a} <= 4'd0;
            dec_enable                   <= 1'b0;
            dec_all_on                   <= 1'b0;
            frame_start                  <= 1'b0;
            bcd_err                      <= 1'b0;
        end else begin
            dig_sel                      <= sel_d;
            {bcd_d, bcd_c, bcd_b, bcd_a} <= nib_d;
            dec_enable                   <= en_d;
            dec_all_on                   <= all_on_d;
            frame_start                  <= fs_d;
            bcd_err                      <= err_d;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver (CLK_DIV=8, BLANK_CYCLES=2): expected slot windows are
// queued per frame by the stimulus; a monitor pops one entry each time a digit window opens.
module tb_seg7_scan_driver;

    localparam int CLK_DIV      = 8;
    localparam int BLANK_CYCLES = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] value = 16'h0000;
    logic        load = 1'b0;
    logic        display_on = 1'b1;
    logic        lamp_test = 1'b0;
    logic        blank_lz = 1'b0;
    logic        bcd_d, bcd_c, bcd_b, bcd_a;
    logic        dec_enable, dec_all_on, frame_start, bcd_err;
    logic [3:0]  dig_sel;

    seg7_scan_driver #(.CLK_DIV(CLK_DIV), .BLANK_CYCLES(BLANK_CYCLES)) dut (
        .clk(clk), .rst(rst), .value(value), .load(load), .display_on(display_on),
        .lamp_test(lamp_test), .blank_lz(blank_lz),
        .bcd_d(bcd_d), .bcd_c(bcd_c), .bcd_b(bcd_b), .bcd_a(bcd_a),
        .dec_enable(dec_enable), .dec_all_on(dec_all_on), .dig_sel(dig_sel),
        .frame_start(frame_start), .bcd_err(bcd_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] sel;
        logic [3:0] nib;
        logic       en;
        logic       all_on;
        logic       err;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    bit   mon_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic pulse_load(input logic [15:0] v);
        value = v;
        load  = 1'b1;
        tick(1);
        load  = 1'b0;
    endtask

    task automatic wait_fs();
        int n = 0;
        do begin
            tick(1);
            n++;
        end while (!frame_start && n < 100);
        check("fs_wait", {31'd0, frame_start}, 32'd1);
    endtask

    task automatic push_frame(input logic [15:0] d, input logic [3:0] en_m, input logic all_on,
                              input logic [3:0] err_m, input int nslots);
        exp_t       e;
        logic [3:0] one = 4'b0001;
        for (int s = 0; s < nslots; s++) begin
            e.sel    = ~(one << s);
            e.nib    = d[4*s +: 4];
            e.en     = en_m[s];
            e.all_on = all_on;
            e.err    = err_m[s];
            sb.push_back(e);
        end
    endtask

    // Monitor: samples on the falling edge, before the stimulus acts (stimulus runs at negedge+1)
    initial begin
        logic [3:0] prev_sel = 4'hF;
        int         since_fs = 0;
        int         win_len  = 0;
        bit         fs_valid = 1'b0;
        exp_t       e;
        exp_t       act;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_sel = 4'hF;
                fs_valid = 1'b0;
                win_len  = 0;
            end else begin
                since_fs++;
                if (!display_on) fs_valid = 1'b0;
                if (frame_start) begin
                    if (fs_valid && mon_en) check("fs_period", since_fs, 32);
                    since_fs = 0;
                    fs_valid = 1'b1;
                end
                act = {dig_sel, bcd_d, bcd_c, bcd_b, bcd_a, dec_enable, dec_all_on, bcd_err};
                if (dig_sel != 4'hF && prev_sel == 4'hF) begin
                    win_len = 0;
                    if (mon_en) begin
                        check("sb_nonempty", {31'd0, sb.size() > 0}, 32'd1);
                        if (sb.size() > 0) begin
                            e = sb.pop_front();
                            check("slot_window", act, e);
                        end
                        if (dig_sel == 4'b1110)
                            check("fs_to_drive", fs_valid ? since_fs : -1, 2);
                    end
                end
                if (dig_sel != 4'hF) win_len++;
                if (dig_sel == 4'hF && prev_sel != 4'hF && mon_en)
                    check("drive_len", win_len, 6);
                if (dig_sel == 4'hF && mon_en)
                    check("blank_quiet", {dec_enable, dec_all_on, bcd_err}, 0);
                prev_sel = dig_sel;
            end
        end
    end

    initial begin
        int viol;
        tick(3);
        check("rst_sel", dig_sel, 4'hF);
        check("rst_nib", {bcd_d, bcd_c, bcd_b, bcd_a}, 4'h0);
        check("rst_ctl", {dec_enable, dec_all_on, frame_start, bcd_err}, 4'h0);

        // idle scan of zeros, load 1234 mid slot 1 (must not show this frame)
        rst = 1'b0;
        wait_fs();
        push_frame(16'h0000, 4'hF, 1'b0, 4'h0, 4);
        mon_en = 1'b1;
        tick(12);
        pulse_load(16'h1234);

        wait_fs();
        push_frame(16'h1234, 4'hF, 1'b0, 4'h0, 4);
        tick(12);
        pulse_load(16'h0040);

        // leading-zero blanking
        wait_fs();
        blank_lz = 1'b1;
        push_frame(16'h0040, 4'b0011, 1'b0, 4'h0, 4);
        tick(12);
        pulse_load(16'h0000);

        wait_fs();
        push_frame(16'h0000, 4'b0001, 1'b0, 4'h0, 4);

        // lamp test overrides blanking
        wait_fs();
        lamp_test = 1'b1;
        push_frame(16'h0000, 4'hF, 1'b1, 4'h0, 4);

        // load on the 3->0 boundary cycle goes straight into the new frame
        wait_fs();
        lamp_test = 1'b0;
        blank_lz  = 1'b0;
        push_frame(16'h0000, 4'hF, 1'b0, 4'h0, 4);
        tick(30);
        pulse_load(16'h9876);

        wait_fs();
        push_frame(16'h9876, 4'hF, 1'b0, 4'h0, 4);
        tick(12);
        pulse_load(16'h00A0);

        // non-BCD digit on slot 1: one bcd_err per frame
        wait_fs();
        push_frame(16'h00A0, 4'hF, 1'b0, 4'b0010, 4);

        wait_fs();
        push_frame(16'h00A0, 4'hF, 1'b0, 4'b0010, 4);
        tick(5);
        pulse_load(16'h1111);
        tick(10);
        pulse_load(16'h5555);

        // last load wins; then reset during slot 2 with a value pending
        wait_fs();
        push_frame(16'h5555, 4'hF, 1'b0, 4'h0, 3);
        tick(12);
        pulse_load(16'h7777);
        tick(7);
        rst = 1'b1;
        #1;
        check("midrst_sel", dig_sel, 4'hF);
        check("midrst_nib", {bcd_d, bcd_c, bcd_b, bcd_a}, 4'h0);
        check("midrst_ctl", {dec_enable, dec_all_on, frame_start, bcd_err}, 4'h0);
        tick(3);

        // display off: everything stays blank, no frame_start
        display_on = 1'b0;
        rst = 1'b0;
        viol = 0;
        for (int i = 0; i < 70; i++) begin
            tick(1);
            if (dig_sel != 4'hF || dec_enable || dec_all_on || frame_start || bcd_err) viol++;
        end
        check("off_blank", viol, 0);

        // back on: disp was cleared and the pending 7777 was lost
        mon_en = 1'b0;
        display_on = 1'b1;
        wait_fs();
        push_frame(16'h0000, 4'hF, 1'b0, 4'h0, 4);
        mon_en = 1'b1;
        wait_fs();
        check("sb_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
